// File: rtl/fib_bcd_converter.sv
// Captures the Fibonacci core's result on busy fall (or a capture pulse), converts it
// to packed BCD with a serial double-dabble engine and offers it on valid/ready.

module fib_bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module fib_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  busy_in,
    input  logic                  capture,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  conv_busy,
    output logic                  overrun
);
    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

    state_t          state, state_n;
    logic            busy_q;
    logic [WIDTH-1:0] sh;
    logic [AW-1:0]   acc, adj;
    logic [CW-1:0]   cnt;
    logic            trigger, load, done, drop;

    assign trigger   = (busy_q & ~busy_in) | capture;
    assign conv_busy = (state == CONVERT);

    // Per-digit correction; digits never carry into each other.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            fib_bcd_add3 u_add3 (.d(acc[4*g +: 4]), .q(adj[4*g +: 4]));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        done    = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: if (trigger) begin
                load    = 1'b1;
                state_n = CONVERT;
            end
            CONVERT: begin
                drop = trigger;
                if (cnt == LAST) begin
                    done    = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                // A trigger coinciding with the handshake is a seamless restart.
                if (ready) begin
                    if (trigger) begin
                        load    = 1'b1;
                        state_n = CONVERT;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    drop = trigger;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            sh      <= '0;
            acc     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy_q <= busy_in;
            if (drop) overrun <= 1'b1;
            if (load) begin
                sh  <= bin_in;
                acc <= '0;
                cnt <= '0;
            end else if (state == CONVERT) begin
                acc <= {adj[AW-2:0], sh[WIDTH-1]};
                sh  <= {sh[WIDTH-2:0], 1'b0};
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                bcd_out <= {adj[AW-2:0], sh[WIDTH-1]};
                valid   <= 1'b1;
            end else if (state == HOLD && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fib_bcd_converter.sv
// Directed bench for fib_bcd_converter: a cycle-level behavioural model checked every
// cycle, plus hand-computed literal expectations at the key points.

module tb_fib_bcd_converter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bin_in = '0;
    logic        busy_in = 1'b0;
    logic        capture = 1'b0;
    logic        ready = 1'b0;
    logic [11:0] bcd_out;
    logic        valid, conv_busy, overrun;

    int nvec = 0;
    int nmis = 0;

    fib_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .busy_in(busy_in), .capture(capture),
        .bcd_out(bcd_out), .valid(valid), .ready(ready), .conv_busy(conv_busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Model: the operand is held for 8 busy cycles, then the decimal digits appear.
    logic [11:0] m_bcd = '0;
    logic        m_valid = 1'b0, m_ovr = 1'b0, m_bq = 1'b0;
    int          m_cnt = 0;
    int          m_op = 0;
    logic        m_trig;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bcd = '0; m_valid = 1'b0; m_ovr = 1'b0; m_bq = 1'b0; m_cnt = 0;
        end else begin
            m_trig = (m_bq & ~busy_in) | capture;
            m_bq   = busy_in;
            if (m_cnt > 0) begin
                if (m_trig) m_ovr = 1'b1;
                m_cnt--;
                if (m_cnt == 0) begin
                    m_bcd   = to_bcd(m_op);
                    m_valid = 1'b1;
                end
            end else if (m_valid) begin
                if (ready) begin
                    m_valid = 1'b0;
                    if (m_trig) begin m_op = int'(bin_in); m_cnt = 8; end
                end else if (m_trig) begin
                    m_ovr = 1'b1;
                end
            end else if (m_trig) begin
                m_op = int'(bin_in); m_cnt = 8;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cmp bcd_out", 32'(bcd_out), 32'(m_bcd));
        check("cmp valid", 32'(valid), 32'(m_valid));
        check("cmp conv_busy", 32'(conv_busy), 32'(m_cnt > 0));
        check("cmp overrun", 32'(overrun), 32'(m_ovr));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single capture-triggered conversion with ready high; result consumed at once.
    task automatic convert(input logic [7:0] v, input logic [11:0] exp, input string nm);
        bin_in = v; capture = 1'b1;
        tick(1);
        capture = 1'b0;
        tick(8);
        check({nm, " valid"}, 32'(valid), 32'd1);
        check({nm, " bcd"}, 32'(bcd_out), 32'(exp));
        tick(1);
        check({nm, " consumed"}, 32'(valid), 32'd0);
    endtask

    initial begin
        // Reset with busy_in toggling
        for (int i = 0; i < 3; i++) begin
            busy_in = ~busy_in;
            tick(1);
            check("rst bcd", 32'(bcd_out), 32'h0);
            check("rst valid", 32'(valid), 32'd0);
            check("rst ovr", 32'(overrun), 32'd0);
            check("rst busy", 32'(conv_busy), 32'd0);
        end
        busy_in = 1'b1;
        rst = 1'b0;
        tick(3);
        check("no false trigger", 32'(conv_busy), 32'd0);

        // Basic conversion of 55 with ready low
        bin_in = 8'd55; busy_in = 1'b0;
        check("T busy", 32'(conv_busy), 32'd0);
        tick(1);
        check("T+1 busy", 32'(conv_busy), 32'd1);
        tick(7);
        check("T+8 busy", 32'(conv_busy), 32'd1);
        check("T+8 valid", 32'(valid), 32'd0);
        tick(1);
        check("T+9 valid", 32'(valid), 32'd1);
        check("T+9 bcd", 32'(bcd_out), 32'h055);
        check("T+9 busy", 32'(conv_busy), 32'd0);
        tick(20);
        check("held valid", 32'(valid), 32'd1);
        check("held bcd", 32'(bcd_out), 32'h055);
        ready = 1'b1;
        tick(1);
        check("accept valid", 32'(valid), 32'd0);
        check("accept bcd kept", 32'(bcd_out), 32'h055);

        // Value sweep
        convert(8'd233, 12'h233, "v233");
        convert(8'd144, 12'h144, "v144");
        convert(8'd255, 12'h255, "v255");
        convert(8'd0,   12'h000, "v0");
        for (int v = 0; v < 256; v++) convert(8'(v), to_bcd(v), "sweep");

        // Back-to-back: trigger in the handshake cycle
        ready = 1'b0; bin_in = 8'd34; capture = 1'b1;
        tick(1);
        capture = 1'b0;
        tick(8);
        check("b2b first", 32'(bcd_out), 32'h034);
        ready = 1'b1; capture = 1'b1; bin_in = 8'd21;
        tick(1);
        capture = 1'b0; ready = 1'b0;
        check("b2b valid low", 32'(valid), 32'd0);
        check("b2b busy", 32'(conv_busy), 32'd1);
        check("b2b ovr", 32'(overrun), 32'd0);
        tick(8);
        check("b2b valid", 32'(valid), 32'd1);
        check("b2b bcd", 32'(bcd_out), 32'h021);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;

        // Overrun during CONVERT and HOLD
        bin_in = 8'd89; capture = 1'b1;
        tick(1);
        capture = 1'b0;
        tick(3);
        bin_in = 8'd13; capture = 1'b1;
        tick(1);
        capture = 1'b0;
        check("ovr set", 32'(overrun), 32'd1);
        tick(4);
        check("ovr valid", 32'(valid), 32'd1);
        check("ovr bcd", 32'(bcd_out), 32'h089);
        capture = 1'b1;
        tick(1);
        capture = 1'b0;
        tick(2);
        check("hold drop bcd", 32'(bcd_out), 32'h089);
        check("hold drop valid", 32'(valid), 32'd1);
        check("ovr sticky", 32'(overrun), 32'd1);
        ready = 1'b1;
        tick(1);

        // Reset mid-conversion
        bin_in = 8'd200; capture = 1'b1;
        tick(1);
        capture = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        check("mid rst bcd", 32'(bcd_out), 32'h0);
        check("mid rst busy", 32'(conv_busy), 32'd0);
        check("mid rst ovr", 32'(overrun), 32'd0);
        check("mid rst valid", 32'(valid), 32'd0);
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("post rst no valid", 32'(valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
